dp_ram_sync_be: RTL and testbench



---
 rtl/ram_pkg.sv | 33 +++
 rtl/ram_clear_seq.sv | 50 +++++
 rtl/dp_ram_sync_be.sv | 110 +++++++++++
 tb/tb_dp_ram_sync_be.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM.
package ram_pkg;

  // Clear sequencer states: CLEAR zero-fills the array, READY serves user ports.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  // Widest word / byte-enable vector the merge helper supports.
  // Callers zero-extend into these widths and truncate the result back.
  localparam int RAM_MAX_DW = 1024;
  localparam int RAM_MAX_BE = RAM_MAX_DW / 8;

  // Byte merge: each byte whose enable bit is set comes from new_word,
  // every other byte keeps old_word. Shared by the write path and the
  // write-first bypass so both always agree on the merged word.
  function automatic logic [RAM_MAX_DW-1:0] be_merge(
    input logic [RAM_MAX_DW-1:0] old_word,
    input logic [RAM_MAX_DW-1:0] new_word,
    input logic [RAM_MAX_BE-1:0] be
  );
    logic [RAM_MAX_DW-1:0] result;
    result = old_word;
    for (int i = 0; i < RAM_MAX_BE; i++) begin
      if (be[i]) begin
        result[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: after reset walks clr_addr over every word, asking the
// top level to write zero, then hands the RAM over to the user ports.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_q, busy_d;

  // Next-state: step the address each CLEAR cycle, leave on the last word.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = READY;
        busy_d  = 1'b0;
      end
    end
  end

  // State registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign init_busy = busy_q;
  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = clr_addr_q;

endmodule

// File: rtl/dp_ram_sync_be.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read
// port with a valid flag, zero-filled by a hardware sweep after reset.
// Build option: define DP_RAM_WR_BYPASS_EN for write-first behaviour on a
// same-address read/write collision; otherwise the read returns old data.
module dp_ram_sync_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  user_ok;
  logic                  wr_fire;
  logic                  rd_fire;

  logic [BE_WIDTH-1:0]   mem_we_be;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_wword;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  ram_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User ports only act once the sweep is done and reset is released.
  assign user_ok = ~init_busy & ~rst;
  assign wr_fire = wr_en & user_ok;
  assign rd_fire = rd_en & user_ok;

  // Write-port mux: the clear sweep takes priority over user writes.
  always_comb begin
    mem_we_be = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_we_be = '1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we_be = wr_be;
    end
    mem_wword = DATA_WIDTH'(be_merge(RAM_MAX_DW'(mem[mem_waddr]),
                                     RAM_MAX_DW'(mem_wdata),
                                     RAM_MAX_BE'(mem_we_be)));
  end

  // Array update; an all-zero byte mask leaves the word untouched.
  always_ff @(posedge clk) begin
    if (|mem_we_be) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // Read-side next values, including the optional same-address bypass.
  always_comb begin
    rd_word = mem[rd_addr];
`ifdef DP_RAM_WR_BYPASS_EN
    if (wr_fire && (wr_addr == rd_addr)) begin
      rd_word = DATA_WIDTH'(be_merge(RAM_MAX_DW'(mem[rd_addr]),
                                     RAM_MAX_DW'(wr_data),
                                     RAM_MAX_BE'(wr_be)));
    end
`endif
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_word : rd_data_q;
  end

  // Registered read outputs; rd_data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_dp_ram_sync_be.sv
// Directed bench for dp_ram_sync_be (32-bit words, 16 entries) with a
// word-level reference model checked on every cycle plus literal checks.
module tb_dp_ram_sync_be;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int n_vec = 0;
  int n_err = 0;

  dp_ram_sync_be #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  // Reference model: whole-word view of the RAM and its read outputs.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_live = 1'b0;
  logic          m_busy;
  int            m_left;
  logic          m_valid;
  logic [DW-1:0] m_data;

  function automatic logic [DW-1:0] apply_bytes(logic [DW-1:0] old_w,
                                                logic [DW-1:0] new_w,
                                                logic [BW-1:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < BW; b++) if (be[b]) mask[b*8 +: 8] = 8'hFF;
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live  = 1'b1;
      m_busy  = 1'b1;
      m_left  = DEPTH;
      m_valid = 1'b0;
      m_data  = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_live && m_busy) begin
      m_left  = m_left - 1;
      m_busy  = (m_left != 0);
      m_valid = 1'b0;
    end else if (m_live) begin
      if (rd_en) begin
        m_data = m_mem[rd_addr];
`ifdef DP_RAM_WR_BYPASS_EN
        if (wr_en && wr_addr == rd_addr) m_data = apply_bytes(m_data, wr_data, wr_be);
`endif
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wr_en) m_mem[wr_addr] = apply_bytes(m_mem[wr_addr], wr_data, wr_be);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      n_vec++;
      if (init_busy !== m_busy || rd_valid !== m_valid || rd_data !== m_data) begin
        n_err++;
        $display("FAIL cycle t=%0t: busy=%0b valid=%0b data=%08h, expected busy=%0b valid=%0b data=%08h",
                 $time, init_busy, rd_valid, rd_data, m_busy, m_valid, m_data);
      end
    end
  end

  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end else begin
      $display("ok   %s: %08h", name, got);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(logic [AW-1:0] a, output logic [DW-1:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  // Counts busy cycles from the current negedge; drops user requests the
  // moment busy clears so nothing is accepted once READY.
  task automatic count_busy(output int cnt, output int valid_seen);
    cnt = 0;
    valid_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (!init_busy) break;
      cnt++;
      if (rd_valid) valid_seen++;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int cnt, vs;

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset rd_data", rd_data, 32'h0);
    check("reset busy", {31'b0, init_busy}, 32'h1);
    rst = 1'b0;

    // Clear sequence length and all-zero contents.
    count_busy(cnt, vs);
    check("clear busy cycles", cnt, 16);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), d);
      check($sformatf("cleared addr %0d", i), d, 32'h0);
    end

    // Reset mid-clear, with user traffic held during CLEAR.
    do_write(4'd3, 32'hDEADBEEF, 4'hF);
    do_read(4'd3, d);
    check("preload addr 3", d, 32'hDEADBEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    count_busy(cnt, vs);
    check("restart busy cycles", cnt, 16);
    check("rd_valid while busy", vs, 0);
    do_read(4'd3, d);
    check("addr 3 after re-clear", d, 32'h0);
    do_read(4'd2, d);
    check("addr 2 write gated", d, 32'h0);

    // Byte enables.
    do_write(4'd5, 32'hAABBCCDD, 4'hF);
    do_write(4'd5, 32'h11223344, 4'h5);
    do_read(4'd5, d);
    check("byte merge addr 5", d, 32'hAA22CC44);

    // No-op write with zero enables.
    do_write(4'd5, 32'hFFFFFFFF, 4'h0);
    do_read(4'd5, d);
    check("be=0 no-op", d, 32'hAA22CC44);

    // Independent write and read at different addresses.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h55AA55AA; wr_be = 4'hF;
    do_read(4'd5, d);
    wr_en = 1'b0;
    check("split-port read", d, 32'hAA22CC44);
    do_read(4'd9, d);
    check("split-port write", d, 32'h55AA55AA);

    // Same-address collision.
    do_write(4'd7, 32'h01020304, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'h3;
    do_read(4'd7, d);
    wr_en = 1'b0;
`ifdef DP_RAM_WR_BYPASS_EN
    check("collision write-first", d, 32'h0102FFFF);
`else
    check("collision read-first", d, 32'h01020304);
`endif
    do_read(4'd7, d);
    check("after collision", d, 32'h0102FFFF);

    // Streaming reads.
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 32'h01010101 * i, 4'hF);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      @(negedge clk);
      check($sformatf("stream %0d valid", i), {31'b0, rd_valid}, 32'h1);
      check($sformatf("stream %0d data", i), rd_data, 32'h01010101 * i);
    end
    rd_en = 1'b0;
    @(negedge clk);
    check("valid drops", {31'b0, rd_valid}, 32'h0);
    check("data holds", rd_data, 32'h0F0F0F0F);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
